// File: rtl/mdu_iter_if.sv
// Issue/writeback handshake between the issue stage and the RV32M multiply/divide unit.
interface mdu_iter_if #(
    parameter int TransIdWidth = 3
);
    logic                    mdu_valid;
    logic                    mdu_ready;
    logic [2:0]              operation;
    logic [31:0]             operand_a;
    logic [31:0]             operand_b;
    logic [TransIdWidth-1:0] trans_id;
    logic                    result_valid;
    logic [31:0]             result;
    logic [TransIdWidth-1:0] result_id;

    modport master (
        output mdu_valid, operation, operand_a, operand_b, trans_id,
        input  mdu_ready, result_valid, result, result_id
    );

    modport slave (
        input  mdu_valid, operation, operand_a, operand_b, trans_id,
        output mdu_ready, result_valid, result, result_id
    );
endinterface

// File: rtl/mdu_iter.sv
// RV32M unit: single-cycle registered multiplies, 32-step restoring divider for DIV/REM.
// Optional MDU_DIV_SHORTCUT_EN: divide-by-zero and signed overflow complete in one cycle.
module mdu_iter #(
    parameter int TransIdWidth = 3,
    parameter int DivCycles    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    mdu_iter_if.slave   mdu
);
    localparam int CntW = $clog2(DivCycles);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    state_e                  r_state, w_state_nxt;
    logic [CntW-1:0]         r_cnt;
    logic [31:0]             r_rem, r_quo, r_dvs;
    logic                    r_qneg, r_rneg, r_is_rem, r_dz, r_ovf;
    logic [TransIdWidth-1:0] r_id;
    logic                    r_res_valid;
    logic [31:0]             r_result;
    logic [TransIdWidth-1:0] r_res_id;

    logic [2:0]  w_op;
    logic [31:0] w_a, w_b;
    logic        w_accept, w_is_div, w_signed_div, w_dz, w_ovf, w_short, w_imm_go, w_div_last;
    logic [31:0] w_a_abs, w_b_abs;
    logic signed [32:0] w_ma, w_mb;
    logic signed [63:0] w_prod;
    logic [31:0] w_mul_res, w_imm_res;
    logic [32:0] w_shift, w_diff;
    logic        w_fit;
    logic [31:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix, w_div_res;

    assign w_op = mdu.operation;
    assign w_a  = mdu.operand_a;
    assign w_b  = mdu.operand_b;

    assign mdu.mdu_ready    = (r_state == IDLE);
    assign mdu.result_valid = r_res_valid;
    assign mdu.result       = r_result;
    assign mdu.result_id    = r_res_id;

    assign w_accept     = mdu.mdu_valid && (r_state == IDLE) && !flush;
    assign w_is_div     = w_op[2];
    assign w_signed_div = !w_op[0];
    assign w_dz         = (w_b == 32'd0);
    assign w_ovf        = w_signed_div && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_a_abs      = (w_signed_div && w_a[31]) ? -w_a : w_a;
    assign w_b_abs      = (w_signed_div && w_b[31]) ? -w_b : w_b;

    // 33-bit operands sign/zero-extended per op; product is exact in 64 bits.
    assign w_ma      = {(w_op[1:0] == 2'd1 || w_op[1:0] == 2'd2) & w_a[31], w_a};
    assign w_mb      = {(w_op[1:0] == 2'd1) & w_b[31], w_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (w_op[1:0] == 2'd0) ? w_prod[31:0] : w_prod[63:32];

`ifdef MDU_DIV_SHORTCUT_EN
    logic [31:0] w_short_res;
    assign w_short     = w_dz || w_ovf;
    assign w_short_res = w_dz ? (w_op[1] ? w_a : 32'hFFFF_FFFF)
                              : (w_op[1] ? 32'd0 : 32'h8000_0000);
    assign w_imm_res   = w_is_div ? w_short_res : w_mul_res;
`else
    assign w_short   = 1'b0;
    assign w_imm_res = w_mul_res;
`endif

    assign w_imm_go   = w_accept && (!w_is_div || w_short);
    assign w_div_last = (r_state == DIV) && (r_cnt == '0);

    // Restoring step: shift in next dividend bit, keep the difference if it fits.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fit     = !w_diff[32];
    assign w_rem_nxt = w_fit ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_fit};

    // Divide-by-zero remainder falls out naturally (|a| re-signed to a).
    assign w_q_fix   = r_dz  ? 32'hFFFF_FFFF :
                       r_ovf ? 32'h8000_0000 :
                       (r_qneg ? -w_quo_nxt : w_quo_nxt);
    assign w_r_fix   = r_ovf ? 32'd0 : (r_rneg ? -w_rem_nxt : w_rem_nxt);
    assign w_div_res = r_is_rem ? w_r_fix : w_q_fix;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept && w_is_div && !w_short) w_state_nxt = DIV;
            DIV:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_rem <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_id     <= '0;
        end else if (w_accept && w_is_div && !w_short) begin
            r_cnt    <= CntW'(DivCycles - 1);
            r_rem    <= '0;
            r_quo    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_qneg   <= w_signed_div && (w_a[31] ^ w_b[31]);
            r_rneg   <= w_signed_div && w_a[31];
            r_is_rem <= w_op[1];
            r_dz     <= w_dz;
            r_ovf    <= w_ovf;
            r_id     <= mdu.trans_id;
        end else if (r_state == DIV) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Output registers hold their value between strobes; flush kills the strobe only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_result    <= '0;
            r_res_id    <= '0;
        end else begin
            r_res_valid <= !flush && (w_imm_go || w_div_last);
            if (w_imm_go) begin
                r_result <= w_imm_res;
                r_res_id <= mdu.trans_id;
            end else if (w_div_last && !flush) begin
                r_result <= w_div_res;
                r_res_id <= r_id;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected result/id/cycle, a monitor pops on result_valid.
module tb_mdu_iter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [2:0]  id_q[$];
    int          due_q[$];

    mdu_iter_if #(.TransIdWidth(3)) m ();
    mdu_iter #(.TransIdWidth(3), .DivCycles(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .mdu   (m)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (m.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h id %0d expected no result (cycle %0d)",
                         m.result, m.result_id, cyc);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic logic [2:0]  i = id_q.pop_front();
                automatic int          d = due_q.pop_front();
                check("result", m.result, e);
                check("result_id", 32'(m.result_id), 32'(i));
                check("result_cycle", cyc, d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    // Called at a negedge; leaves at the next negedge (cycle T+1) with mdu_valid low.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] id, input logic [31:0] exp, input int lat, input bit push);
        check("ready_at_issue", 32'(m.mdu_ready), 32'd1);
        m.mdu_valid = 1'b1;
        m.operation = op;
        m.operand_a = a;
        m.operand_b = b;
        m.trans_id  = id;
        if (push) begin
            exp_q.push_back(exp);
            id_q.push_back(id);
            due_q.push_back(cyc + 1 + lat);
        end
        @(negedge clock);
        m.mdu_valid = 1'b0;
    endtask

    // Enter at T+1: ready must stay low through T+33 despite junk requests, high at T+34.
    task automatic busy_wait();
        for (int i = 0; i < 33; i++) begin
            check("ready_busy", 32'(m.mdu_ready), 32'd0);
            m.mdu_valid = (i < 32) && (i % 2 == 0);
            m.operation = 3'd0;
            m.operand_a = 32'(i);
            m.operand_b = 32'd1;
            m.trans_id  = 3'd7;
            @(negedge clock);
        end
        m.mdu_valid = 1'b0;
        check("ready_after_div", 32'(m.mdu_ready), 32'd1);
    endtask

    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] id, input logic [31:0] exp, input bit special);
        int lat;
        lat = 32;
`ifdef MDU_DIV_SHORTCUT_EN
        if (special) lat = 0;
`endif
        issue(op, a, b, id, exp, lat, 1'b1);
        if (lat == 0) check("ready_shortcut", 32'(m.mdu_ready), 32'd1);
        else          busy_wait();
    endtask

    initial begin
        m.mdu_valid = 1'b0;
        m.operation = 3'd0;
        m.operand_a = '0;
        m.operand_b = '0;
        m.trans_id  = '0;
        repeat (3) @(negedge clock);
        check("reset_result_valid", 32'(m.result_valid), 32'd0);
        check("reset_result", m.result, 32'd0);
        check("reset_result_id", 32'(m.result_id), 32'd0);
        check("reset_ready", 32'(m.mdu_ready), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        // Back-to-back multiplies, then output hold
        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 3'd5, 32'hFFFF_FFEB, 0, 1'b1);
        issue(3'd0, 32'h0000_1234, 32'h0000_0010, 3'd6, 32'h0001_2340, 0, 1'b1);
        @(negedge clock);
        check("hold_valid", 32'(m.result_valid), 32'd0);
        check("hold_result", m.result, 32'h0001_2340);
        check("hold_id", 32'(m.result_id), 32'd6);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000, 0, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFE, 0, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFF, 0, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 3'd4, 32'h4000_0000, 0, 1'b1);
        @(negedge clock);

        // Regular divides
        run_div(3'd4, 32'hFFFF_FFEC, 32'd3, 3'd1, 32'hFFFF_FFFA, 1'b0);
        run_div(3'd6, 32'hFFFF_FFEC, 32'd3, 3'd2, 32'hFFFF_FFFE, 1'b0);
        run_div(3'd5, 32'd100, 32'd7, 3'd3, 32'd14, 1'b0);
        run_div(3'd7, 32'd100, 32'd7, 3'd4, 32'd2, 1'b0);
        run_div(3'd4, 32'd7, 32'hFFFF_FFFE, 3'd5, 32'hFFFF_FFFD, 1'b0);
        run_div(3'd6, 32'd7, 32'hFFFF_FFFE, 3'd6, 32'd1, 1'b0);
        run_div(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0);
        run_div(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 32'h8000_0000, 1'b0);

        // Divide-by-zero and signed overflow
        run_div(3'd4, 32'h1234_5678, 32'd0, 3'd2, 32'hFFFF_FFFF, 1'b1);
        run_div(3'd6, 32'h1234_5678, 32'd0, 3'd3, 32'h1234_5678, 1'b1);
        run_div(3'd6, 32'hFFFF_FFF0, 32'd0, 3'd4, 32'hFFFF_FFF0, 1'b1);
        run_div(3'd5, 32'h8000_0001, 32'd0, 3'd5, 32'hFFFF_FFFF, 1'b1);
        run_div(3'd7, 32'h8000_0001, 32'd0, 3'd6, 32'h8000_0001, 1'b1);
        run_div(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 32'h8000_0000, 1'b1);
        run_div(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b1);

        // Flush at T+10 of a divide
        issue(3'd4, 32'd1000, 32'd7, 3'd2, 32'd0, 32, 1'b0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("ready_after_flush", 32'(m.mdu_ready), 32'd1);
        issue(3'd0, 32'd6, 32'd7, 3'd3, 32'd42, 0, 1'b1);

        // Request coincident with flush while idle is dropped
        flush       = 1'b1;
        m.mdu_valid = 1'b1;
        m.operation = 3'd0;
        m.operand_a = 32'd3;
        m.operand_b = 32'd3;
        m.trans_id  = 3'd1;
        @(negedge clock);
        flush       = 1'b0;
        m.mdu_valid = 1'b0;
        check("flush_drops_req", 32'(m.result_valid), 32'd0);

        // Reset at T+5 of a divide
        issue(3'd5, 32'd1000, 32'd7, 3'd4, 32'd0, 32, 1'b0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset_mid_valid", 32'(m.result_valid), 32'd0);
        check("reset_mid_ready", 32'(m.mdu_ready), 32'd1);
        run_div(3'd5, 32'd9, 32'd3, 3'd5, 32'd3, 1'b0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        repeat (40) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
